mul_div_unit: RTL and testbench
===============================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL use clock clk; reset reset, synchronous, active-high.
REQ-002 clk  input  1  rising-edge clock shared with the register file.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 start  input  1  request pulse; operands, op and rd_in are sampled on the same edge.
REQ-005 op  input  2  operation: 0=MUL (low 64), 1=MULHU (high 64, unsigned), 2=DIVU, 3=REMU.
REQ-006 rs1_data  input  64  first operand, driven from register-file ReadData1.
REQ-007 rs2_data  input  64  second operand, driven from register-file ReadData2.
REQ-008 rd_in  input  5  destination register index for the request.
REQ-009 busy  output  1  unit is occupied; new start is ignored.
REQ-010 done  output  1  one-cycle pulse; result/rd_out are valid; doubles as register-file RegWrite.
REQ-011 result  output  64  operation result; feeds register-file WriteData.
REQ-012 rd_out  output  5  latched rd_in; feeds register-file RD.

Function
REQ-013 The FSM SHALL have states IDLE, MUL, DIV and DONE.
REQ-014 In IDLE with start=1, the op SHALL be latched; the FSM SHALL go to MUL for op 0/1 and to DIV for op 2/3.
REQ-015 The iteration counter SHALL be 7 bits, cleared on accept; MUL/DIV SHALL run exactly 64 iterations, one per cycle, then enter DONE.
REQ-016 MUL SHALL use unsigned shift-add into a 128-bit product; MUL returns bits [63:0]; MULHU returns bits [127:64].
REQ-017 DIV SHALL use unsigned restoring division with a 64-bit quotient and a 65-bit partial remainder.
REQ-018 Divisor 0 SHALL give quotient 0xFFFF_FFFF_FFFF_FFFF (DIVU) and remainder = dividend (REMU), with no special-case latency.
REQ-019 Latency: start accepted at edge N -> done=1 during the cycle after edge N+65; fixed for all ops and operands.
REQ-020 busy SHALL be 1 in MUL, DIV and DONE, and 0 only in IDLE.
REQ-021 done SHALL be 1 only in DONE; DONE SHALL last one cycle, then IDLE.
REQ-022 start while busy=1 SHALL be ignored, with no effect on latched operands, op or rd_out.
REQ-023 start in the IDLE cycle immediately following DONE SHALL be accepted (back-to-back throughput 66 cycles).
REQ-024 result and rd_out SHALL hold their values after done until the next DONE; intermediate values SHALL NOT appear on result.
REQ-025 Operand inputs SHALL NOT be required stable after the accept edge.

Reset
REQ-026 reset=1 at a clock edge SHALL force IDLE, busy=0, done=0, result=0, rd_out=0, counter=0, and clear internal product/remainder.
REQ-027 reset mid-operation SHALL abort it with no done pulse; the first start after reset deasserts SHALL be processed normally.
REQ-028 reset SHALL take priority over start at the same edge.

Structure
REQ-029 A shared package mdu_pkg SHALL hold XLEN=64, ITER=64, op encodings (OP_MUL, OP_MULHU, OP_DIVU, OP_REMU) and the state enum.
REQ-030 The block SHALL be a single module with no sub-module; one datapath register set shared by MUL and DIV.

Verification
REQ-031 MUL 7 x 6, rd_in=5 -> done exactly 65 cycles after accept, result=42, rd_out=5, busy low next cycle.
REQ-032 MULHU 0xFFFF_FFFF_FFFF_FFFF x 2 -> result=1; MUL same operands -> result=0xFFFF_FFFF_FFFF_FFFE.
REQ-033 DIVU 100/7 -> result=14; REMU 100/7 -> result=2; issued back-to-back with start in the IDLE cycle after done.
REQ-034 DIVU 5/0 -> result=0xFFFF_FFFF_FFFF_FFFF; REMU 5/0 -> result=5; latency unchanged at 65.
REQ-035 Start MUL 3x3, pulse start with DIVU 9/3 at iteration 10 -> ignored, result=9; then reset at iteration 30 of a new op -> busy=0, done never pulses, result=0; next MUL 2x2 -> result=4.

Source files
------------

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared constants, op encodings and FSM states for the mul/div unit
package mdu_pkg;

  localparam int XLEN = 64;
  localparam int ITER = 64;

  localparam logic [1:0] OP_MUL   = 2'd0;
  localparam logic [1:0] OP_MULHU = 2'd1;
  localparam logic [1:0] OP_DIVU  = 2'd2;
  localparam logic [1:0] OP_REMU  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative 64-bit unsigned multiply/divide unit, fixed 65-cycle latency
module mul_div_unit
  import mdu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam logic [6:0] ITER_CNT = 7'(ITER);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [1:0]      r_op;
  logic [6:0]      r_cnt;
  logic [4:0]      r_rd;
  // Shared datapath: r_hi is the product high half (MUL) or partial remainder (DIV);
  // r_lo is the multiplier shifting out / product low half, or dividend shifting out / quotient.
  logic [XLEN:0]   r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_b;
  logic [XLEN-1:0] r_result;
  logic [4:0]      r_rd_out;

  logic            w_iterating;
  logic [XLEN:0]   w_mul_sum;
  logic [XLEN:0]   w_div_shift;
  logic [XLEN+1:0] w_div_diff;
  logic            w_div_fits;
  logic [XLEN-1:0] w_final;

  assign w_iterating = (r_cnt != ITER_CNT);

  // Shift-add step: conditionally add the multiplicand into the high half before shifting right.
  assign w_mul_sum = r_lo[0] ? (r_hi + {1'b0, r_b}) : r_hi;

  // Restoring step: bring in the next dividend bit and trial-subtract the divisor.
  // A zero divisor always "fits", which naturally yields all-ones quotient and remainder = dividend.
  assign w_div_shift = {r_hi[XLEN-1:0], r_lo[XLEN-1]};
  assign w_div_diff  = {1'b0, w_div_shift} - {2'b00, r_b};
  assign w_div_fits  = ~w_div_diff[XLEN+1];

  // Low-half ops (MUL, DIVU) read r_lo; high-half ops (MULHU, REMU) read r_hi.
  assign w_final = r_op[0] ? r_hi[XLEN-1:0] : r_lo;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic and status outputs.
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b1;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) w_state_nxt = op[1] ? DIV : MUL;
      end
      MUL:  if (!w_iterating) w_state_nxt = DONE;
      DIV:  if (!w_iterating) w_state_nxt = DONE;
      DONE: begin
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: latch request in IDLE, iterate 64 times, then publish result on the DONE transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op     <= OP_MUL;
      r_cnt    <= '0;
      r_rd     <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_rd_out <= '0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_op  <= op;
          r_cnt <= '0;
          r_rd  <= rd_in;
          r_hi  <= '0;
          r_lo  <= rs1_data;
          r_b   <= rs2_data;
        end
        MUL: begin
          if (w_iterating) begin
            r_hi  <= {1'b0, w_mul_sum[XLEN:1]};
            r_lo  <= {w_mul_sum[0], r_lo[XLEN-1:1]};
            r_cnt <= r_cnt + 7'd1;
          end else begin
            r_result <= w_final;
            r_rd_out <= r_rd;
          end
        end
        DIV: begin
          if (w_iterating) begin
            r_hi  <= w_div_fits ? w_div_diff[XLEN:0] : w_div_shift;
            r_lo  <= {r_lo[XLEN-2:0], w_div_fits};
            r_cnt <= r_cnt + 7'd1;
          end else begin
            r_result <= w_final;
            r_rd_out <= r_rd;
          end
        end
        default: ;
      endcase
    end
  end

  assign result = r_result;
  assign rd_out = r_rd_out;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - self-checking bench for mul_div_unit with vector table and scoreboard
module tb_mul_div_unit;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [63:0] rs1_data;
  logic [63:0] rs2_data;
  logic [4:0]  rd_in;
  logic        busy;
  logic        done;
  logic [63:0] result;
  logic [4:0]  rd_out;

  mul_div_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_in(rd_in),
    .busy(busy), .done(done), .result(result), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  rd;
    logic [63:0] exp;
  } vec_t;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  rd;
    int          acc;
  } sb_t;

  vec_t vecs[$];
  sb_t  sbq[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] p;
    p = {64'd0, a} * {64'd0, b};
    case (o)
      OP_MUL:   return p[63:0];
      OP_MULHU: return p[127:64];
      OP_DIVU:  return (b == 64'd0) ? {64{1'b1}} : a / b;
      default:  return (b == 64'd0) ? a : a % b;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called #1 after an edge while the unit is idle; returns #1 after the accept edge.
  task automatic do_start(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b,
                          input logic [4:0] rd, input bit push);
    sb_t e;
    op = o; rs1_data = a; rs2_data = b; rd_in = rd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    op = 2'($urandom); rs1_data = {$urandom, $urandom}; rs2_data = {$urandom, $urandom}; rd_in = 5'($urandom);
    if (push) begin
      e.res = ref_model(o, a, b);
      e.rd  = rd;
      e.acc = cyc;
      sbq.push_back(e);
    end
  endtask

  // Waits for done, compares against the scoreboard head, then steps into the following idle cycle.
  task automatic wait_done(input string name);
    sb_t e;
    int k = 0;
    while (!done && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    if (sbq.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL %s_sb: scoreboard empty at done=%0d", name, done);
      return;
    end
    e = sbq.pop_front();
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL %s_timeout: done not seen after %0d cycles, required 65", name, k);
      return;
    end
    check({name, "_latency"}, 64'(cyc - e.acc), 64'd65);
    check({name, "_result"}, result, e.res);
    check({name, "_rd"}, 64'(rd_out), 64'(e.rd));
    check({name, "_busy_done"}, 64'(busy), 64'd1);
    @(posedge clk); #1;
    check({name, "_busy_after"}, 64'(busy), 64'd0);
    check({name, "_done_after"}, 64'(done), 64'd0);
    check({name, "_hold"}, result, e.res);
  endtask

  initial begin
    int pulses;
    reset = 1'b1; start = 1'b0; op = '0; rs1_data = '0; rs2_data = '0; rd_in = '0;

    vecs.push_back('{OP_MUL,   64'd7,              64'd6, 5'd5,  64'd42});
    vecs.push_back('{OP_MULHU, {64{1'b1}},         64'd2, 5'd6,  64'd1});
    vecs.push_back('{OP_MUL,   {64{1'b1}},         64'd2, 5'd7,  64'hFFFF_FFFF_FFFF_FFFE});
    vecs.push_back('{OP_DIVU,  64'd100,            64'd7, 5'd8,  64'd14});
    vecs.push_back('{OP_REMU,  64'd100,            64'd7, 5'd9,  64'd2});
    vecs.push_back('{OP_DIVU,  64'd5,              64'd0, 5'd10, {64{1'b1}}});
    vecs.push_back('{OP_REMU,  64'd5,              64'd0, 5'd11, 64'd5});
    vecs.push_back('{OP_MULHU, {64{1'b1}},         {64{1'b1}}, 5'd12, 64'hFFFF_FFFF_FFFF_FFFE});
    vecs.push_back('{OP_DIVU,  64'd3,              64'd10, 5'd13, 64'd0});
    vecs.push_back('{OP_REMU,  64'd3,              64'd10, 5'd14, 64'd3});
    for (int i = 0; i < 8; i++) begin
      vec_t v;
      v.op = 2'(i);
      v.a  = {$urandom, $urandom};
      v.b  = (i >= 4) ? 64'($urandom_range(1, 1000)) : {$urandom, $urandom};
      v.rd = 5'(16 + i);
      v.exp = ref_model(v.op, v.a, v.b);
      vecs.push_back(v);
    end

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_result", result, 64'd0);
    check("reset_rd", 64'(rd_out), 64'd0);

    // Table vectors, each issued in the idle cycle right after the previous done.
    foreach (vecs[i]) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      do_start(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, 1'b1);
      check({nm, "_expected"}, sbq[0].res, vecs[i].exp);
      wait_done(nm);
    end

    // Start while busy must be ignored.
    do_start(OP_MUL, 64'd3, 64'd3, 5'd1, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    op = OP_DIVU; rs1_data = 64'd9; rs2_data = 64'd3; rd_in = 5'd2; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done("ignored_start");
    check("ignored_result9", result, 64'd9);

    // Reset mid-operation, asserted together with start: aborts with no done pulse.
    do_start(OP_MULHU, {64{1'b1}}, 64'd12345, 5'd20, 1'b0);
    repeat (30) @(posedge clk);
    #1;
    reset = 1'b1; start = 1'b1; op = OP_MUL; rs1_data = 64'd8; rs2_data = 64'd8; rd_in = 5'd21;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_result", result, 64'd0);
    check("abort_rd", 64'(rd_out), 64'd0);
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check("abort_no_done", 64'(pulses), 64'd0);
    check("abort_idle", 64'(busy), 64'd0);

    do_start(OP_MUL, 64'd2, 64'd2, 5'd4, 1'b1);
    wait_done("post_reset");
    check("post_reset_result4", result, 64'd4);

    check("sb_empty", 64'(sbq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
